// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: bus command codes and FSM states.
package dmem_pkg;

  localparam logic [7:0] CMD_READ  = 8'h00;
  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_NOP   = 8'h02;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_CAPTURE = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-way round-robin picker: masks requests by eligibility and breaks ties
// in favour of the port that did not win last.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic [1:0] elig,
  output logic [1:0] gnt
);

  logic [1:0] cand;

  always_comb begin
    cand = req & elig;
    gnt  = cand;
    if (cand == 2'b11) gnt = last ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Serialises two requesters onto the single data-memory bus, with round-robin
// tie-breaking and bounded locked bursts.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       p0_req,
  input  logic       p0_we,
  input  logic       p0_lock,
  input  logic [7:0] p0_addr,
  input  logic [7:0] p0_wdata,
  output logic       p0_gnt,
  output logic       p0_done,
  output logic [7:0] p0_rdata,
  input  logic       p1_req,
  input  logic       p1_we,
  input  logic       p1_lock,
  input  logic [7:0] p1_addr,
  input  logic [7:0] p1_wdata,
  output logic       p1_gnt,
  output logic       p1_done,
  output logic [7:0] p1_rdata,
  output logic [7:0] cmd_memory,
  output logic [7:0] addr_memory,
  inout  wire  [7:0] data_memory
);

  localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST);

  state_t     state_q, state_d;
  logic       owner_q, last_q, we_q, drive_q;
  logic       lock_q, lock_d;
  logic [3:0] burst_q, burst_d, burst_inc;
  logic [7:0] wdata_q;
  logic [1:0] req, elig, pick, gnt;
  logic       accept, win, win_we, win_lock, owner_req;
  logic [7:0] win_addr, win_wdata;

  assign req       = {p1_req, p0_req};
  assign owner_req = owner_q ? p1_req : p0_req;
  // A held lock narrows eligibility to the owner only while it keeps requesting.
  assign elig      = (lock_q && owner_req) ? (owner_q ? 2'b10 : 2'b01) : 2'b11;

  rr_pick2 u_pick (
    .req  (req),
    .last (last_q),
    .elig (elig),
    .gnt  (pick)
  );

  assign gnt       = (rst_n && state_q == ST_IDLE) ? pick : 2'b00;
  assign p0_gnt    = gnt[0];
  assign p1_gnt    = gnt[1];
  assign accept    = |gnt;
  assign win       = gnt[1];
  assign win_we    = win ? p1_we    : p0_we;
  assign win_lock  = win ? p1_lock  : p0_lock;
  assign win_addr  = win ? p1_addr  : p0_addr;
  assign win_wdata = win ? p1_wdata : p0_wdata;

  assign data_memory = drive_q ? wdata_q : 8'bz;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      lock_q  <= 1'b0;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
      burst_q <= burst_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    lock_d    = lock_q;
    burst_d   = burst_q;
    burst_inc = (lock_q && owner_req) ? burst_q + 4'd1 : 4'd1;
    case (state_q)
      ST_IDLE: begin
        if (lock_q && !owner_req) begin
          lock_d  = 1'b0;
          burst_d = '0;
        end
        if (accept) begin
          state_d = ST_ACCESS;
          // Reaching the limit releases the lock; the pointer then favours the other port.
          if (win_lock && burst_inc < BURST_LIMIT) begin
            lock_d  = 1'b1;
            burst_d = burst_inc;
          end else begin
            lock_d  = 1'b0;
            burst_d = '0;
          end
        end
      end
      ST_ACCESS:  state_d = we_q ? ST_IDLE : ST_CAPTURE;
      ST_CAPTURE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      drive_q     <= 1'b0;
      cmd_memory  <= CMD_NOP;
      addr_memory <= '0;
      p0_done     <= 1'b0;
      p1_done     <= 1'b0;
      p0_rdata    <= '0;
      p1_rdata    <= '0;
    end else begin
      p0_done <= 1'b0;
      p1_done <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            owner_q     <= win;
            last_q      <= win;
            we_q        <= win_we;
            wdata_q     <= win_wdata;
            addr_memory <= win_addr;
            drive_q     <= win_we;
            cmd_memory  <= win_we ? CMD_WRITE : CMD_READ;
          end
        end
        ST_ACCESS: begin
          if (we_q) begin
            cmd_memory <= CMD_NOP;
            drive_q    <= 1'b0;
            if (owner_q) p1_done <= 1'b1;
            else         p0_done <= 1'b1;
          end
        end
        ST_CAPTURE: begin
          cmd_memory <= CMD_NOP;
          if (owner_q) begin
            p1_rdata <= data_memory;
            p1_done  <= 1'b1;
          end else begin
            p0_rdata <= data_memory;
            p0_done  <= 1'b1;
          end
        end
        default: cmd_memory <= CMD_NOP;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a vector table of single-port accesses plus hand-written
// reset, round-robin, burst-limit and lock-release sequences, checked by a done scoreboard.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  typedef struct {
    bit         port;
    bit         we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
  } vec_t;

  typedef struct {
    bit         port;
    bit         we;
    logic [7:0] rdata;
  } sb_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       p0_req = 1'b0, p0_we = 1'b0, p0_lock = 1'b0;
  logic [7:0] p0_addr = '0, p0_wdata = '0;
  logic       p1_req = 1'b0, p1_we = 1'b0, p1_lock = 1'b0;
  logic [7:0] p1_addr = '0, p1_wdata = '0;
  logic       p0_gnt, p0_done, p1_gnt, p1_done;
  logic [7:0] p0_rdata, p1_rdata, cmd_memory, addr_memory;
  wire  [7:0] data_memory;

  logic [7:0] mem [256];
  sb_t        sb [$];
  sb_t        mon_e;
  logic [7:0] last_rd [2];
  vec_t       vecs [9];
  int         vectors = 0;
  int         miscompares = 0;
  int         who;

  dmem_arbiter #(.MAX_BURST(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_lock(p0_lock), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_gnt(p0_gnt), .p0_done(p0_done), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_lock(p1_lock), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_gnt(p1_gnt), .p1_done(p1_done), .p1_rdata(p1_rdata),
    .cmd_memory(cmd_memory), .addr_memory(addr_memory), .data_memory(data_memory)
  );

  always #5 clk = ~clk;

  // Asynchronous-read memory on the shared bus.
  assign data_memory = (cmd_memory == CMD_READ) ? mem[addr_memory] : 8'bz;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[8'h20] = 8'h3C;
    forever begin
      @(posedge clk);
      if (rst_n && cmd_memory == CMD_WRITE) mem[addr_memory] <= data_memory;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // A released bus reads as z, or as 0 on two-state simulators.
  function automatic bit bus_free(input logic [7:0] v);
    return (v === 8'bz) || (v === 8'h00);
  endfunction

  function automatic logic done_of(input bit port);
    return port ? p1_done : p0_done;
  endfunction

  task automatic set_port(input bit port, input bit req, input bit we,
                          input logic [7:0] addr, input logic [7:0] wdata, input bit lock);
    if (port) begin
      p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wdata; p1_lock = lock;
    end else begin
      p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wdata; p0_lock = lock;
    end
  endtask

  // Called at a falling edge; returns the granted port, or -1 if none within the budget.
  task automatic wait_grant(output int port);
    port = -1;
    for (int n = 0; n < 16 && port < 0; n++) begin
      if (n > 0) @(negedge clk);
      #1;
      check("gnt_onehot", 32'({p1_gnt, p0_gnt} != 2'b11), 1);
      if (p0_gnt) port = 0;
      else if (p1_gnt) port = 1;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int w;
    set_port(v.port, 1'b1, v.we, v.addr, v.wdata, 1'b0);
    wait_grant(w);
    check("vec_gnt", w, v.port);
    sb.push_back('{v.port, v.we, v.rdata});
    @(negedge clk);
    set_port(v.port, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    #1;
    check("vec_cmd", cmd_memory, v.we ? CMD_WRITE : CMD_READ);
    check("vec_addr", addr_memory, v.addr);
    check("vec_bus", data_memory, v.we ? v.wdata : v.rdata);
    if (!v.we) begin
      @(negedge clk);
      check("cap_cmd", cmd_memory, CMD_READ);
      check("cap_addr", addr_memory, v.addr);
      check("cap_done", done_of(v.port), 0);
    end
    @(negedge clk);
    check("vec_done", done_of(v.port), 1);
    check("idle_cmd", cmd_memory, CMD_NOP);
    check("idle_bus", bus_free(data_memory), 1);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      last_rd[0] = 8'h00;
      last_rd[1] = 8'h00;
    end else if (p0_done || p1_done) begin
      if (sb.size() == 0) begin
        check("done_unexpected", {p1_done, p0_done}, 2'b00);
      end else begin
        mon_e = sb.pop_front();
        check("done_port", {p1_done, p0_done}, mon_e.port ? 2'b10 : 2'b01);
        if (!mon_e.we) begin
          check("rdata", mon_e.port ? p1_rdata : p0_rdata, mon_e.rdata);
          last_rd[mon_e.port] = mon_e.rdata;
        end
        check("rdata_hold", mon_e.port ? p0_rdata : p1_rdata, last_rd[~mon_e.port]);
      end
    end
  end

  initial begin
    //          port  we    addr   wdata  rdata
    vecs[0] = '{1'b0, 1'b1, 8'h10, 8'hA5, 8'h00};
    vecs[1] = '{1'b1, 1'b0, 8'h20, 8'h00, 8'h3C};
    vecs[2] = '{1'b0, 1'b0, 8'h10, 8'h00, 8'hA5};
    vecs[3] = '{1'b1, 1'b1, 8'hFF, 8'h5A, 8'h00};
    vecs[4] = '{1'b1, 1'b0, 8'hFF, 8'h00, 8'h5A};
    vecs[5] = '{1'b0, 1'b1, 8'h00, 8'h00, 8'h00};
    vecs[6] = '{1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
    vecs[7] = '{1'b1, 1'b0, 8'h10, 8'h00, 8'hA5};
    vecs[8] = '{1'b0, 1'b0, 8'h7F, 8'h00, 8'h25};

    // Reset state, with a request pending that must not be granted.
    #3 rst_n = 1'b0;
    p0_req = 1'b1;
    #10;
    check("rst_gnt", p0_gnt, 0);
    check("rst_cmd", cmd_memory, CMD_NOP);
    check("rst_addr", addr_memory, 8'h00);
    check("rst_done", {p1_done, p0_done}, 2'b00);
    check("rst_rdata", {p1_rdata, p0_rdata}, 16'h0000);
    check("rst_bus", bus_free(data_memory), 1);
    p0_req = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);
    check("mem_10", mem[8'h10], 8'hA5);

    // Reset in the middle of a read.
    set_port(1'b1, 1'b1, 1'b0, 8'h20, 8'h00, 1'b0);
    wait_grant(who);
    check("mid_gnt", who, 1);
    sb.push_back('{1'b1, 1'b0, 8'h3C});
    @(negedge clk);
    set_port(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    #1;
    check("mid_cmd_read", cmd_memory, CMD_READ);
    rst_n = 1'b0;
    #1;
    check("mid_rst_cmd", cmd_memory, CMD_NOP);
    check("mid_rst_addr", addr_memory, 8'h00);
    check("mid_rst_bus", bus_free(data_memory), 1);
    check("mid_rst_done", {p1_done, p0_done}, 2'b00);
    check("mid_rst_rdata", {p1_rdata, p0_rdata}, 16'h0000);
    @(negedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("mid_no_done", {p1_done, p0_done}, 2'b00);
      check("mid_idle_cmd", cmd_memory, CMD_NOP);
    end

    // Continuous tie: pointer starts at 1, so grants alternate 0,1,0,1.
    set_port(1'b0, 1'b1, 1'b1, 8'h50, 8'hC0, 1'b0);
    set_port(1'b1, 1'b1, 1'b1, 8'h51, 8'hC1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      wait_grant(who);
      check("tie_order", who, i % 2);
      sb.push_back('{who[0], 1'b1, 8'h00});
      @(negedge clk);
    end
    set_port(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    set_port(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    repeat (3) @(negedge clk);

    // Locked p1 read burst with p0 waiting: four p1 accesses, then p0.
    set_port(1'b1, 1'b1, 1'b0, 8'h20, 8'h00, 1'b1);
    wait_grant(who);
    check("burst_first", who, 1);
    sb.push_back('{1'b1, 1'b0, 8'h3C});
    @(negedge clk);
    set_port(1'b0, 1'b1, 1'b1, 8'h30, 8'h77, 1'b0);
    for (int k = 0; k < 3; k++) begin
      wait_grant(who);
      check("burst_hold", who, 1);
      sb.push_back('{1'b1, 1'b0, 8'h3C});
      @(negedge clk);
    end
    wait_grant(who);
    check("burst_release", who, 0);
    sb.push_back('{1'b0, 1'b1, 8'h00});
    @(negedge clk);
    set_port(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    set_port(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    repeat (4) @(negedge clk);

    // Lock holds while p0 keeps requesting, then releases the cycle p0 goes idle.
    set_port(1'b0, 1'b1, 1'b1, 8'h40, 8'h11, 1'b1);
    wait_grant(who);
    check("lock_first", who, 0);
    sb.push_back('{1'b0, 1'b1, 8'h00});
    @(negedge clk);
    set_port(1'b0, 1'b1, 1'b1, 8'h42, 8'h33, 1'b1);
    set_port(1'b1, 1'b1, 1'b1, 8'h41, 8'h22, 1'b0);
    wait_grant(who);
    check("lock_hold", who, 0);
    sb.push_back('{1'b0, 1'b1, 8'h00});
    @(negedge clk);
    set_port(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    #1;
    check("lock_access_gnt", {p1_gnt, p0_gnt}, 2'b00);
    @(negedge clk);
    #1;
    check("lock_idle_gnt", {p1_gnt, p0_gnt}, 2'b10);
    sb.push_back('{1'b1, 1'b1, 8'h00});
    @(negedge clk);
    set_port(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    repeat (3) @(negedge clk);

    check("mem_30", mem[8'h30], 8'h77);
    check("mem_40", mem[8'h40], 8'h11);
    check("mem_41", mem[8'h41], 8'h22);
    check("mem_42", mem[8'h42], 8'h33);
    check("mem_51", mem[8'h51], 8'hC1);
    check("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
